// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute-stage ALU of the 16-bit pipelined core. Decodes op/func into a
//   3-bit ALU operation, evaluates it on two 16-bit operands and registers
//   the result into the EX/MEM position. Also provides the fetch-stage PC+1.
//
// Ports
//   CLK       in   1   pipeline clock, rising edge
//   RST_N     in   1   asynchronous active-low reset (clears result_q only)
//   op        in   4   opcode of the instruction in EX
//   func      in   3   R-type function field (used when op == 0)
//   in_a      in  16   first operand (0xFFFF for FOR decrement)
//   in_b      in  16   second operand (register or extended immediate)
//   pc        in  16   current program counter
//   alu_op    out  3   decoded ALU operation (comb)
//   result    out 16   ALU result (comb)
//   zero      out  1   result == 0 (comb)
//   result_q  out 16   result registered on CLK
//   next_pc   out 16   pc + 1, wraps at 2^16 (comb)
module alu_exec_unit (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  op,
  input  logic [2:0]  func,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [15:0] pc,
  output logic [2:0]  alu_op,
  output logic [15:0] result,
  output logic        zero,
  output logic [15:0] result_q,
  output logic [15:0] next_pc
);

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_SLL   = 3'b011;
  localparam logic [2:0] ALU_SRL   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  // Opcode decode. Everything that is not R-type, ANDI or a branch compare
  // (loads, stores, FOR, jumps, calls, spare opcodes) uses the adder.
  always_comb begin
    alu_op = ALU_ADD;
    unique case (op)
      4'd0:       alu_op = func;
      4'd1:       alu_op = ALU_AND;
      4'd5, 4'd6: alu_op = ALU_SUB;
      default:    alu_op = ALU_ADD;
    endcase
  end

  // Shift amount is only the low nibble of in_b; upper bits are ignored.
  logic [3:0] shamt;
  assign shamt = in_b[3:0];

  always_comb begin
    result = 16'h0000;
    unique case (alu_op)
      ALU_AND:   result = in_a & in_b;
      ALU_ADD:   result = in_a + in_b;
      ALU_SUB:   result = in_a - in_b;
      ALU_SLL:   result = in_a << shamt;
      ALU_SRL:   result = in_a >> shamt;
      ALU_OR:    result = in_a | in_b;
      ALU_XOR:   result = in_a ^ in_b;
      ALU_PASSB: result = in_b;
      default:   result = 16'h0000;
    endcase
  end

  assign zero    = (result == 16'h0000);
  assign next_pc = pc + 16'd1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) result_q <= 16'h0000;
    else        result_q <= result;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//   Scoreboard bench: the stimulus process drives one instruction per cycle
//   and queues its expected combinational response; a monitor on the falling
//   edge pops and compares, then queues the same result as the expectation
//   for result_q one cycle later. Directed vectors carry literal expected
//   values; random vectors use an arithmetic reference model.
module tb_alu_exec_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  op = '0;
  logic [2:0]  func = '0;
  logic [15:0] in_a = '0, in_b = '0, pc = '0;
  logic [2:0]  alu_op;
  logic [15:0] result, result_q, next_pc;
  logic        zero;

  alu_exec_unit dut (
    .CLK(CLK), .RST_N(RST_N), .op(op), .func(func), .in_a(in_a), .in_b(in_b),
    .pc(pc), .alu_op(alu_op), .result(result), .zero(zero),
    .result_q(result_q), .next_pc(next_pc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [2:0]  alu;
    logic [15:0] res;
    logic [15:0] npc;
  } exp_t;

  exp_t        comb_q[$];
  logic [15:0] reg_q[$];
  string       reg_name_q[$];
  int          total = 0;
  int          passed = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    else passed++;
  endtask

  // Reference model: plain integer arithmetic modulo 2^16.
  function automatic exp_t model(input string name, input int o, input int f,
                                 input int a, input int b, input int p);
    exp_t e;
    int sel;
    longint r;
    int sh;
    sel = (o == 0) ? f : (o == 1) ? 0 : (o == 5 || o == 6) ? 2 : 1;
    sh  = b % 16;
    case (sel)
      0: r = a & b;
      1: r = (a + b) % 65536;
      2: r = (a - b + 65536) % 65536;
      3: r = (longint'(a) * (longint'(1) << sh)) % 65536;
      4: r = a / (1 << sh);
      5: r = a | b;
      6: r = a ^ b;
      default: r = b;
    endcase
    e.name = name;
    e.alu  = 3'(sel);
    e.res  = 16'(r);
    e.npc  = 16'((p + 1) % 65536);
    return e;
  endfunction

  task automatic issue(input int o, input int f, input int a, input int b,
                       input int p, input exp_t e);
    op   = 4'(o);
    func = 3'(f);
    in_a = 16'(a);
    in_b = 16'(b);
    pc   = 16'(p);
    comb_q.push_back(e);
  endtask

  // Monitor
  always @(negedge CLK) begin
    if (mon_en) begin
      if (reg_q.size() > 0) begin
        string n;
        n = reg_name_q.pop_front();
        chk({n, "_result_q"}, result_q, reg_q.pop_front());
      end
      if (comb_q.size() > 0) begin
        exp_t e;
        e = comb_q.pop_front();
        chk({e.name, "_alu_op"}, {13'd0, alu_op}, {13'd0, e.alu});
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_zero"}, {15'd0, zero}, {15'd0, (e.res == 16'h0000)});
        chk({e.name, "_next_pc"}, next_pc, e.npc);
        reg_q.push_back(e.res);
        reg_name_q.push_back(e.name);
      end
    end
  end

  // Directed table: op, func, a, b, pc, expected alu_op, expected result
  typedef struct { string n; int o; int f; int a; int b; int p; int alu; int res; } dir_t;
  dir_t dirs[$];

  initial begin
    dirs = '{
      '{"r_and",   0, 0, 'h00F0, 'h0003, 'h0000, 0, 'h0000},
      '{"r_add",   0, 1, 'h00F0, 'h0003, 'h01FF, 1, 'h00F3},
      '{"r_sub",   0, 2, 'h00F0, 'h0003, 'hFFFF, 2, 'h00ED},
      '{"r_sll",   0, 3, 'h00F0, 'h0003, 'h0010, 3, 'h0780},
      '{"r_srl",   0, 4, 'h00F0, 'h0003, 'h0020, 4, 'h001E},
      '{"r_or",    0, 5, 'h00F0, 'h0003, 'h0030, 5, 'h00F3},
      '{"r_xor",   0, 6, 'h00F0, 'h0003, 'h0040, 6, 'h00F3},
      '{"r_passb", 0, 7, 'h00F0, 'h0003, 'h0050, 7, 'h0003},
      '{"addi",    2, 0, 'h0010, 'hFFFE, 'h0060, 1, 'h000E},
      '{"lw",      3, 5, 'h0010, 'hFFFE, 'h0070, 1, 'h000E},
      '{"sw",      4, 3, 'h0010, 'hFFFE, 'h0080, 1, 'h000E},
      '{"andi",    1, 2, 'h0F0F, 'h00FF, 'h0090, 0, 'h000F},
      '{"beq",     5, 0, 'h1234, 'h1234, 'h00A0, 2, 'h0000},
      '{"bne",     6, 7, 'h1234, 'h1235, 'h00B0, 2, 'hFFFF},
      '{"for_1",   7, 0, 'hFFFF, 'h0001, 'h00C0, 1, 'h0000},
      '{"for_0",   7, 0, 'hFFFF, 'h0000, 'h00D0, 1, 'hFFFF},
      '{"jmp12",  12, 4, 'h0001, 'h0001, 'h00E0, 1, 'h0002},
      '{"sll_max", 0, 3, 'h0001, 'hFFFF, 'h00F0, 3, 'h8000}
    };
  end

  initial begin
    int drained;
    // Reset state
    #2;
    chk("reset_result_q", result_q, 16'h0000);
    @(posedge CLK); #1;
    chk("reset_held_result_q", result_q, 16'h0000);
    @(negedge CLK);
    RST_N  = 1'b1;
    mon_en = 1'b1;

    foreach (dirs[i]) begin
      exp_t e;
      @(posedge CLK); #1;
      e.name = dirs[i].n;
      e.alu  = 3'(dirs[i].alu);
      e.res  = 16'(dirs[i].res);
      e.npc  = 16'((dirs[i].p + 1) % 65536);
      issue(dirs[i].o, dirs[i].f, dirs[i].a, dirs[i].b, dirs[i].p, e);
    end

    for (int i = 0; i < 200; i++) begin
      int o, f, a, b, p;
      o = int'($urandom_range(0, 15));
      f = int'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 'hFFFF : int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) b = a;
      p = int'($urandom_range(0, 65535));
      @(posedge CLK); #1;
      issue(o, f, a, b, p, model("rand", o, f, a, b, p));
    end

    // Drain scoreboard, bounded
    drained = 0;
    for (int c = 0; c < 10 && !drained; c++) begin
      @(posedge CLK); #1;
      if (comb_q.size() == 0 && reg_q.size() == 0) drained = 1;
    end
    total++;
    if (!drained) $display("FAIL drain pending=%0d expected=0", comb_q.size() + reg_q.size());
    else passed++;
    mon_en = 1'b0;

    // Register / asynchronous reset sequence
    op = 4'd2; func = 3'd0; in_a = 16'h0002; in_b = 16'h0003;
    @(posedge CLK); #1;
    chk("seq_add_result_q", result_q, 16'h0005);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("async_reset_result_q", result_q, 16'h0000);
    chk("reset_comb_result", result, 16'h0005);
    op = 4'd5; in_a = 16'h0005; in_b = 16'h0007;
    @(posedge CLK); #1;
    chk("reset_hold_result_q", result_q, 16'h0000);
    #2;
    RST_N = 1'b1;
    #1;
    chk("release_no_load", result_q, 16'h0000);
    @(posedge CLK); #1;
    chk("seq_sub_result_q", result_q, 16'hFFFE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic block of the 16-bit pipelined processor: decodes the 4-bit opcode and 3-bit function field into a 3-bit ALU operation, evaluates that operation on two 16-bit operands, and registers the result into the EX/MEM pipeline position. It also provides the fetch-stage sequential PC incrementer (PC+1). All arithmetic is 16-bit, two's complement, modulo 2^16.

## Interface

- No parameters; data width fixed at 16 bits.
- One clock; reset is asynchronous and active-low.
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- op  in  4  instruction opcode of the instruction in EX.
- func  in  3  function field, meaningful only when op = 0 (R-type).
- in_a  in  16  first ALU operand (already forwarded and muxed upstream, e.g. 0xFFFF for FOR).
- in_b  in  16  second ALU operand (register or extended immediate).
- pc  in  16  current program counter.
- alu_op  out  3  decoded ALU operation, combinational.
- result  out  16  ALU result, combinational.
- zero  out  1  high when result = 0x0000, combinational.
- result_q  out  16  result registered on CLK (EX/MEM value).
- next_pc  out  16  pc + 1, combinational.

## Operation

- ALU operation codes: 000 AND, 001 ADD, 010 SUB (in_a - in_b), 011 SLL, 100 SRL, 101 OR, 110 XOR, 111 PASSB (result = in_b).
- Opcode decode (alu_op): op 0 -> from func (func value used directly as alu_op); op 1 ANDI -> AND; op 2 ADDI -> ADD; op 3 LW -> ADD; op 4 SW -> ADD; op 5 BEQ -> SUB; op 6 BNE -> SUB; op 7 FOR -> ADD; op 8-15 (jumps, calls, unused) -> ADD.
- ADD/SUB: 16-bit wrap-around, no carry or overflow output, no exception.
- SLL/SRL: shift in_a by in_b[3:0] (0-15); in_b[15:4] ignored; SRL is logical (zero fill).
- FOR loop decrement: upstream drives in_a = 0xFFFF, op = 7 -> result = in_b - 1.
- zero derived from result of the current operation, regardless of opcode.
- next_pc = pc + 1 modulo 2^16; 0xFFFF -> 0x0000; independent of clock/reset.
- result_q captures result every rising CLK edge; no enable, no stall input (stall bubbles are inserted upstream).

## Timing

- alu_op, result, zero, next_pc: purely combinational, valid within the same cycle as inputs.
- result_q: one-cycle latency; value at edge N+1 reflects inputs stable before edge N+1.
- Reset: RST_N low forces result_q = 0x0000 immediately (asynchronous), held while low; combinational outputs unaffected by reset.
- Reset deassertion: result_q loads on the first rising CLK edge after RST_N goes high; deassertion coincident with an edge ignores that edge.
- Reset mid-operation: in-flight result discarded; no residual state beyond result_q.
- Undefined op/func combinations do not exist: every 7-bit op/func value maps to a defined alu_op.

## Test plan

- R-type sweep: op=0, in_a=0x00F0, in_b=0x0003, func 0..7 -> result 0x0000, 0x00F3, 0x00ED, 0x0780, 0x001E, 0x00F3, 0x00F3, 0x0003; zero high only for func=0.
- Immediate/memory: op=2, in_a=0x0010, in_b=0xFFFE -> alu_op=001, result=0x000E; op=3 and op=4 same result; op=1, in_a=0x0F0F, in_b=0x00FF -> 0x000F.
- Branch compare: op=5, in_a=in_b=0x1234 -> result 0x0000, zero=1; op=6, in_a=0x1234, in_b=0x1235 -> result 0xFFFF, zero=0.
- FOR decrement: op=7, in_a=0xFFFF, in_b=0x0001 -> result 0x0000, zero=1; in_b=0x0000 -> result 0xFFFF; op=12 -> alu_op=001.
- PC increment: pc=0x0000 -> next_pc 0x0001; pc=0x01FF -> 0x0200; pc=0xFFFF -> 0x0000.
- Register/reset: drive ADD 0x0002+0x0003, clock -> result_q 0x0005 after edge; assert RST_N low between edges -> result_q 0x0000 immediately; release, next edge with SUB 5-7 -> result_q 0xFFFE.
